// File: rtl/accum_checker_pkg.sv
// Shared types and constants for the accumulator output-stream checker.
// Holds the default data width, the checker state encoding and the saturation helper.
package accum_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } checkState_t;

    // All-ones value of a w-bit counter, for w up to 32
    function automatic logic [31:0] maxCount(input int unsigned w);
        if (w >= 32) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/accum_checker_if.sv
// Sample stream from the accumulator plus the checker's status results.
// The master drives samples and observes results; the slave is the checker.
interface accum_checker_if
    import accum_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = 8
);
    logic                 valid;
    logic [WIDTH-1:0]     GreyIn;
    logic [WIDTH-1:0]     ValueIn;
    logic                 OverflowIn;
    logic [WIDTH-1:0]     BinaryOut;
    logic                 OutValid;
    logic                 Locked;
    logic                 Mismatch;
    logic                 StepError;
    logic [ERR_CNT_W-1:0] ErrorCount;
    logic                 OverflowSeen;

    modport master (
        output valid, GreyIn, ValueIn, OverflowIn,
        input  BinaryOut, OutValid, Locked, Mismatch, StepError, ErrorCount, OverflowSeen
    );

    modport slave (
        input  valid, GreyIn, ValueIn, OverflowIn,
        output BinaryOut, OutValid, Locked, Mismatch, StepError, ErrorCount, OverflowSeen
    );
endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder of parameterized width.
// Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
module gray_to_bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] grey,
    output logic [WIDTH-1:0] binary
);
    for (genvar i = 0; i < WIDTH; i++) begin : gDecode
        assign binary[i] = ^(grey >> i);
    end
endmodule

// File: rtl/accum_checker.sv
// Receive-side checker for the accumulator stream: Gray/binary agreement, step legality,
// lock tracking, saturating error count and sticky overflow capture.
module accum_checker
    import accum_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = 8,
    parameter int SYNC_LEN  = 2
) (
    input logic            clock,
    input logic            reset,
    input logic            clear,
    accum_checker_if.slave bus
);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = ERR_CNT_W'(maxCount(ERR_CNT_W));
    localparam logic [3:0]           SYNC_TARGET = 4'(SYNC_LEN);

    checkState_t      state;
    logic [3:0]       syncCnt;
    logic [WIDTH-1:0] prevValue;
    logic [WIDTH-1:0] decoded;
    logic             consistent;
    logic             legalStep;
    logic             stepBad;
    logic             sampleBad;

    gray_to_bin #(.WIDTH(WIDTH)) uDecoder (
        .grey   (bus.GreyIn),
        .binary (decoded)
    );

    // Without a reference value (IDLE) a step cannot be judged, so only SYNC/LOCKED flag it
    assign consistent = (decoded == bus.ValueIn);
    assign legalStep  = (decoded == prevValue) || (decoded == prevValue + WIDTH'(1));
    assign stepBad    = (state != IDLE) && !legalStep;
    assign sampleBad  = !consistent || stepBad;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state            <= IDLE;
            syncCnt          <= '0;
            prevValue        <= '0;
            bus.BinaryOut    <= '0;
            bus.OutValid     <= 1'b0;
            bus.Locked       <= 1'b0;
            bus.Mismatch     <= 1'b0;
            bus.StepError    <= 1'b0;
            bus.ErrorCount   <= '0;
            bus.OverflowSeen <= 1'b0;
        end else begin
            bus.OutValid  <= bus.valid;
            bus.Mismatch  <= bus.valid && !consistent;
            bus.StepError <= bus.valid && stepBad;
            if (bus.valid) begin
                bus.BinaryOut <= decoded;
                prevValue     <= decoded;
                if (sampleBad && (bus.ErrorCount != ERR_MAX)) begin
                    bus.ErrorCount <= bus.ErrorCount + ERR_CNT_W'(1);
                end
                if (bus.OverflowIn) begin
                    bus.OverflowSeen <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (consistent) begin
                            syncCnt <= 4'd1;
                            if (SYNC_TARGET == 4'd1) begin
                                state      <= LOCKED;
                                bus.Locked <= 1'b1;
                            end else begin
                                state <= SYNC;
                            end
                        end
                    end
                    SYNC: begin
                        if (sampleBad) begin
                            state   <= IDLE;
                            syncCnt <= '0;
                        end else begin
                            syncCnt <= syncCnt + 4'd1;
                            if (syncCnt + 4'd1 == SYNC_TARGET) begin
                                state      <= LOCKED;
                                bus.Locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (sampleBad) begin
                            state      <= IDLE;
                            syncCnt    <= '0;
                            bus.Locked <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        syncCnt    <= '0;
                        bus.Locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/accum_checker.md
# accum_checker

Receive-side checker for the accumulator's output stream. Each valid sample carries the accumulator value, its Gray-coded copy and the overflow flag. The block decodes the Gray word, confirms that it matches the binary value, and confirms that the value holds or advances by exactly one per sample. It locks after a run of consistent samples, pulses error flags, keeps a saturating error count, and records overflow as a sticky flag. It sits downstream of the accumulator as a self-check and bring-up aid.

## Interface
- WIDTH, 8, data width of value and Gray words
- ERR_CNT_W, 8, width of the saturating error counter
- SYNC_LEN, 2, consecutive consistent samples required to lock (1..15)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; highest priority
- clear  in  1  synchronous clear; same effect as reset, lower priority than reset
- valid  in  1  sample strobe; inputs are sampled only when valid=1
- GreyIn  in  WIDTH  Gray-coded accumulator value
- ValueIn  in  WIDTH  binary accumulator value
- OverflowIn  in  1  accumulator overflow flag
- BinaryOut  out  WIDTH  decoded Gray value of the last accepted sample
- OutValid  out  1  one-cycle pulse for each accepted sample
- Locked  out  1  high while in the LOCKED state
- Mismatch  out  1  one-cycle pulse when decoded Gray != ValueIn
- StepError  out  1  one-cycle pulse when the value step is illegal (SYNC/LOCKED only)
- ErrorCount  out  ERR_CNT_W  count of erroneous samples, saturating at all-ones
- OverflowSeen  out  1  sticky; set by any accepted sample with OverflowIn=1

## Operation
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- A sample is consistent when decoded == ValueIn.
- A step is legal when decoded == prev or decoded == prev+1 mod 2^WIDTH. The wrap FF→00 is legal at WIDTH=8.
- prev is the decoded value of the previous accepted sample. It updates on every accepted sample, including erroneous ones.
- States:
  - IDLE: no reference value held. On valid: consistent → SYNC with sync_cnt=1, or LOCKED if SYNC_LEN=1. Inconsistent → stay in IDLE, pulse Mismatch. StepError is never raised in IDLE.
  - SYNC: on valid, consistent with a legal step → sync_cnt+1, and → LOCKED when it reaches SYNC_LEN. Any error → IDLE.
  - LOCKED: on valid, consistent with a legal step → stay. Any error → IDLE and Locked falls.
- An erroneous sample is one with Mismatch or StepError (or both). ErrorCount increments by exactly 1 per erroneous sample, even when both flags fire, and stops at 2^ERR_CNT_W-1.
- OverflowSeen is cleared only by reset or clear.
- When valid=0 the state, prev and BinaryOut hold.
- Priority: reset > clear > valid. A sample arriving together with clear is discarded.

## Timing
- All outputs are registered, with latency of 1 cycle from the valid sample edge.
- Reset/clear values: BinaryOut=0, OutValid=0, Locked=0, Mismatch=0, StepError=0, ErrorCount=0, OverflowSeen=0, state=IDLE, sync_cnt=0, prev=0.
- Locked rises in the cycle after the SYNC_LEN-th consistent sample.
- Locked falls in the cycle after the first erroneous sample, in the same cycle as the error pulse.
- Back-to-back valid samples are supported every cycle, with no bubbles.

## Structure
- Package accum_pkg holds:
  - the WIDTH default,
  - the state enum typedef (IDLE, SYNC, LOCKED),
  - the max-count constant helper.
- Sub-module gray_to_bin is a purely combinational, WIDTH-parameterized decoder, instantiated once.
- The top level holds the state register, sync_cnt, prev, the output registers and the saturating counter.

## Test plan
- Lock-up: reset, then valid samples (Grey,Value) = (00,00), (01,01). Required: Locked=1 one cycle after the 2nd sample, ErrorCount=0, BinaryOut=01.
- Mismatch: while locked at 04, send Grey=07 with Value=06. Required: BinaryOut=05, Mismatch=1 for one cycle, StepError=0, ErrorCount=1, Locked=0.
- Step error: while locked at 03, send Grey=07 with Value=05. Required: StepError=1, Mismatch=0, ErrorCount=1, state IDLE. Then send (06,04) and (07,05). Required: Locked=1 again.
- Wrap/overflow: while locked at FF (Grey=80), send Grey=00, Value=00, OverflowIn=1. Required: no error pulses, Locked stays 1, OverflowSeen=1 and still 1 after 10 idle cycles.
- Saturation: with ERR_CNT_W=2, send 5 mismatching samples. Required: ErrorCount reads 1,2,3,3,3.
- Clear collision: while locked with ErrorCount=2, assert clear and valid together with a mismatching sample. Required: next cycle shows all outputs 0, Mismatch=0, state IDLE.
